wca_iq_framer: RTL

Sits directly downstream of the DDC decimator in the receive path. Accepts the decimator's strobed 32-bit I/Q samples (Q in [31:16], I in [15:0]) and buffers them in a small FIFO. Emits fixed-length frames of 16-bit words to the host-transfer port over a valid/ready handshake. Detects and counts overruns when the host side stalls.

---
 rtl/wca_framer_pkg.sv | 22 ++
 rtl/wca_sync_fifo.sv | 78 +++++++
 rtl/wca_iq_framer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/wca_framer_pkg.sv
// wca_framer_pkg
//   Shared definitions for the I/Q framer:
//     - state_e      : framer FSM states (IDLE, HDR, IWORD, QWORD)
//     - SYNC_DEFAULT : default sync byte placed in header bits [15:8]
//     - build_header : forms the 16-bit frame header {sync, seq}
package wca_framer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        IWORD = 2'd2,
        QWORD = 2'd3
    } state_e;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    function automatic logic [15:0] build_header(input logic [7:0] sync,
                                                 input logic [7:0] seq);
        return {sync, seq};
    endfunction

endpackage

// File: rtl/wca_sync_fifo.sv
// wca_sync_fifo
//   Single-clock show-ahead FIFO: the entry at the read pointer is always
//   visible on head_o, and pop_i simply advances past it.
//   Ports:
//     clock, reset      : clock, asynchronous active-high reset
//     clear_i           : synchronous clear of pointers and level
//     push_i, din_i     : write request and data; taken when not full, or
//                         when a pop happens in the same cycle
//     pop_i             : read advance; ignored when empty
//     head_o            : current head entry (asynchronous read)
//     full_o, empty_o   : occupancy flags
//     level_o           : occupancy 0..2^ADDR_W
module wca_sync_fifo #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [WIDTH-1:0]  din_i,
    input  logic              pop_i,
    output logic [WIDTH-1:0]  head_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   level_o
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   level_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (level_q == DEPTH_L);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO still takes a write when the head leaves in the same cycle:
    // the freed slot is the one the write pointer is about to land on.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + ONE_L;
                2'b01:   level_q <= level_q - ONE_L;
                default: level_q <= level_q;
            endcase
        end
    end

    // NOTE: storage has no reset; pointers and level define which entries are
    // meaningful, so resetting the array would only cost flops.
    always_ff @(posedge clock) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/wca_iq_framer.sv
// wca_iq_framer
//   Buffers strobed 32-bit {Q,I} samples from the decimator and emits
//   fixed-length frames of 16-bit words: header {SYNC, seq}, then I0, Q0,
//   I1, Q1, ... A frame is started only once all of its samples are buffered.
//   Rejected pushes (FIFO full, no same-cycle pop) set a sticky overflow flag
//   and bump a saturating drop counter.
//   Ports:
//     clock, reset        : clock, asynchronous active-high reset
//     aclr                : synchronous clear of FIFO, FSM, seq, overflow, drops
//     enable              : gates input strobes; an active frame still drains
//     dstrobe_in, iq_in   : sample strobe and {Q[15:0], I[15:0]}
//     dout, dvalid, dready: output word handshake
//     overflow            : sticky dropped-sample flag
//     drop_count          : saturating dropped-sample count
//     level               : FIFO occupancy
module wca_iq_framer
    import wca_framer_pkg::*;
#(
    parameter int         FRAME_SAMPLES = 16,
    parameter int         ADDR_W        = 5,
    parameter logic [7:0] SYNC          = SYNC_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              aclr,
    input  logic              enable,
    input  logic              dstrobe_in,
    input  logic [31:0]       iq_in,
    output logic [15:0]       dout,
    output logic              dvalid,
    input  logic              dready,
    output logic              overflow,
    output logic [15:0]       drop_count,
    output logic [ADDR_W:0]   level
);

    localparam logic [ADDR_W:0] FRAME_L = (ADDR_W+1)'(FRAME_SAMPLES);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

    state_e          state_q, state_d;
    logic [7:0]      seq_q, seq_d;
    logic [ADDR_W:0] remain_q, remain_d;
    logic [15:0]     hdr_q, hdr_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     drop_q, drop_d;

    logic            push_req;
    logic            pop;
    logic            drop;
    logic [31:0]     fifo_head;
    logic            fifo_full;
    logic            fifo_empty;

    wca_sync_fifo #(
        .WIDTH  (32),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .clear_i (aclr),
        .push_i  (push_req),
        .din_i   (iq_in),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    // aclr wins over a same-cycle strobe, so the strobe is neither stored
    // nor counted as a drop.
    assign push_req = dstrobe_in & enable & ~aclr;
    assign drop     = push_req & fifo_full & ~pop;

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        remain_d = remain_q;
        hdr_d    = hdr_q;
        pop      = 1'b0;
        dvalid   = 1'b0;
        dout     = '0;

        unique case (state_q)
            IDLE: begin
                remain_d = FRAME_L;
                if (level >= FRAME_L) begin
                    state_d = HDR;
                    hdr_d   = build_header(SYNC, seq_q);
                end
            end
            HDR: begin
                dvalid = 1'b1;
                dout   = hdr_q;
                if (dready) begin
                    state_d = IWORD;
                    seq_d   = seq_q + 8'd1;
                end
            end
            IWORD: begin
                dvalid = 1'b1;
                dout   = fifo_head[15:0];
                if (dready) state_d = QWORD;
            end
            QWORD: begin
                dvalid = 1'b1;
                dout   = fifo_head[31:16];
                if (dready) begin
                    pop      = ~fifo_empty;
                    remain_d = remain_q - ONE_L;
                    state_d  = (remain_q > ONE_L) ? IWORD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (aclr) begin
            state_d = IDLE;
            seq_d   = '0;
            pop     = 1'b0;
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (aclr) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            seq_q      <= '0;
            remain_q   <= FRAME_L;
            hdr_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            remain_q   <= remain_d;
            hdr_q      <= hdr_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule
